// File: rtl/isa_pkg.sv
// Shared ISA constants for the 16-bit MIPS datapath (opcode map, formats, loader error codes).
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: opcode constants, instruction format enum, err_code constants, opcode->format helper.
package isa_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_R_FIRST = 4'h1;
  localparam logic [3:0] OP_R_LAST  = 4'h8;
  localparam logic [3:0] OP_ADDI    = 4'h9;
  localparam logic [3:0] OP_LOAD    = 4'hA;
  localparam logic [3:0] OP_STORE   = 4'hB;
  localparam logic [3:0] OP_BR      = 4'hC;
  localparam logic [3:0] OP_JMP     = 4'hD;

  typedef enum logic [2:0] {
    FMT_NOP,
    FMT_R,
    FMT_I,
    FMT_B,
    FMT_J,
    FMT_ILL
  } fmt_e;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL_OP = 2'b01;
  localparam logic [1:0] ERR_IMM_RANGE  = 2'b10;
  localparam logic [1:0] ERR_ADDR_OVF   = 2'b11;

  function automatic fmt_e op_format(input logic [3:0] op);
    fmt_e f;
    if (op == OP_NOP)
      f = FMT_NOP;
    else if (op >= OP_R_FIRST && op <= OP_R_LAST)
      f = FMT_R;
    else if (op == OP_ADDI || op == OP_LOAD || op == OP_STORE)
      f = FMT_I;
    else if (op == OP_BR)
      f = FMT_B;
    else if (op == OP_JMP)
      f = FMT_J;
    else
      f = FMT_ILL;
    return f;
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Packs decoded instruction fields into a 16-bit word and flags illegal bundles.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: opcode/a/b/c/imm in; word, legal, err_code out (err_code is ERR_NONE when legal).
module instr_field_packer
  import isa_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  a,
  input  logic [2:0]  b,
  input  logic [2:0]  c,
  input  logic [11:0] imm,
  output logic [15:0] word,
  output logic        legal,
  output logic [1:0]  err_code
);

  fmt_e fmt;
  logic imm6_ok;

  assign fmt = op_format(opcode);
  // imm fits a signed 6-bit field only when bits [11:5] are a pure sign extension
  assign imm6_ok = (imm[11:5] == 7'h00) || (imm[11:5] == 7'h7F);

  always_comb begin
    word     = 16'h0000;
    legal    = 1'b1;
    err_code = ERR_NONE;
    case (fmt)
      FMT_NOP: word = 16'h0000;
      FMT_R:   word = {opcode, a, b, c, 3'b000};
      FMT_I, FMT_B: begin
        word = {opcode, a, b, imm[5:0]};
        if (!imm6_ok) begin
          legal    = 1'b0;
          err_code = ERR_IMM_RANGE;
        end
      end
      FMT_J:   word = {opcode, imm};
      default: begin
        legal    = 1'b0;
        err_code = ERR_ILLEGAL_OP;
      end
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Loads a stream of field bundles into instruction memory as encoded words, stalling the core meanwhile.
// Latency: handshake in N -> imem_we in N+1 -> fld_ready again in N+2 (one word per 2 cycles).
// Backpressure: fld_ready is low outside LOAD, so bundles are only taken one at a time inside a session.
// Ports: clk/rst_n; start/base_addr session control; fld_* valid/ready bundle in;
//        imem_we/addr/wdata write port; cpu_hold, done pulse, sticky err/err_code, wr_count.
module instr_stream_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              fld_valid,
  output logic              fld_ready,
  input  logic [3:0]        fld_opcode,
  input  logic [2:0]        fld_a,
  input  logic [2:0]        fld_b,
  input  logic [2:0]        fld_c,
  input  logic [11:0]       fld_imm,
  input  logic              fld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e      state;
  logic        last_q;
  logic [15:0] pk_word;
  logic        pk_legal;
  logic [1:0]  pk_code;

  instr_field_packer u_packer (
    .opcode   (fld_opcode),
    .a        (fld_a),
    .b        (fld_b),
    .c        (fld_c),
    .imm      (fld_imm),
    .word     (pk_word),
    .legal    (pk_legal),
    .err_code (pk_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_q     <= 1'b0;
      fld_ready  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 16'h0000;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      wr_count   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_LOAD;
            imem_addr <= base_addr;
            wr_count  <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            cpu_hold  <= 1'b1;
            fld_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (fld_valid && fld_ready) begin
            fld_ready <= 1'b0;
            last_q    <= fld_last;
            if (pk_legal) begin
              imem_wdata <= pk_word;
              imem_we    <= 1'b1;
              state      <= S_WRITE;
            end else begin
              err      <= 1'b1;
              err_code <= pk_code;
              state    <= S_ERR;
            end
          end
        end
        S_WRITE: begin
          imem_we  <= 1'b0;
          wr_count <= wr_count + CNT_ONE;
          if (last_q) begin
            state    <= S_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else if (imem_addr == {ADDR_W{1'b1}}) begin
            // top of memory reached with more words pending: abort rather than wrap
            err      <= 1'b1;
            err_code <= ERR_ADDR_OVF;
            state    <= S_ERR;
          end else begin
            imem_addr <= imem_addr + ADDR_ONE;
            fld_ready <= 1'b1;
            state     <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
module tb_instr_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        fld_valid = 1'b0;
  logic        fld_ready;
  logic [3:0]  fld_opcode = '0;
  logic [2:0]  fld_a = '0;
  logic [2:0]  fld_b = '0;
  logic [2:0]  fld_c = '0;
  logic [11:0] fld_imm = '0;
  logic        fld_last = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [8:0]  wr_count;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;

  instr_stream_encoder #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .fld_valid  (fld_valid),
    .fld_ready  (fld_ready),
    .fld_opcode (fld_opcode),
    .fld_a      (fld_a),
    .fld_b      (fld_b),
    .fld_c      (fld_c),
    .fld_imm    (fld_imm),
    .fld_last   (fld_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && imem_we) wr_seen++;

  typedef struct {
    logic [7:0]  base;
    logic [3:0]  op;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  c;
    logic [11:0] imm;
    logic        legal;
    logic [15:0] word;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    check("start_ready", fld_ready, 1);
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] c, input logic [11:0] imm, input logic last);
    int n;
    fld_opcode = op; fld_a = a; fld_b = b; fld_c = c; fld_imm = imm; fld_last = last;
    fld_valid = 1'b1;
    n = 0;
    while (!fld_ready && n < 20) begin
      tick();
      n++;
    end
    check("hs_ready", fld_ready, 1);
    tick();
    fld_valid = 1'b0;
  endtask

  initial begin
    int w0;
    vecs[0]  = '{8'h10, 4'h1, 3'd1, 3'd2, 3'd3, 12'h000, 1'b1, 16'h1298, 2'b00};
    vecs[1]  = '{8'h20, 4'h8, 3'd7, 3'd7, 3'd7, 12'h000, 1'b1, 16'h8FF8, 2'b00};
    vecs[2]  = '{8'h30, 4'h9, 3'd2, 3'd0, 3'd0, 12'hFFF, 1'b1, 16'h943F, 2'b00};
    vecs[3]  = '{8'h40, 4'hB, 3'd5, 3'd3, 3'd0, 12'h01F, 1'b1, 16'hBADF, 2'b00};
    vecs[4]  = '{8'h50, 4'hC, 3'd0, 3'd1, 3'd0, 12'hFE0, 1'b1, 16'hC060, 2'b00};
    vecs[5]  = '{8'h60, 4'hD, 3'd0, 3'd0, 3'd0, 12'hABC, 1'b1, 16'hDABC, 2'b00};
    vecs[6]  = '{8'h70, 4'h0, 3'd7, 3'd5, 3'd3, 12'h123, 1'b1, 16'h0000, 2'b00};
    vecs[7]  = '{8'h80, 4'hA, 3'd1, 3'd1, 3'd0, 12'h020, 1'b0, 16'h0000, 2'b10};
    vecs[8]  = '{8'h90, 4'hE, 3'd1, 3'd1, 3'd1, 12'h000, 1'b0, 16'h0000, 2'b01};
    vecs[9]  = '{8'hA0, 4'hF, 3'd0, 3'd0, 3'd0, 12'h000, 1'b0, 16'h0000, 2'b01};
    vecs[10] = '{8'hB0, 4'h9, 3'd3, 3'd4, 3'd0, 12'hFDF, 1'b0, 16'h0000, 2'b10};
    vecs[11] = '{8'hC0, 4'hC, 3'd0, 3'd0, 3'd0, 12'h7FF, 1'b0, 16'h0000, 2'b10};

    // reset values
    #2;
    check("rst_ready", fld_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", {err, err_code}, 0);
    check("rst_cnt", wr_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // bundles offered with no session are not accepted
    fld_opcode = 4'h1; fld_valid = 1'b1;
    repeat (3) tick();
    check("idle_ready", fld_ready, 0);
    check("idle_nowrite", wr_seen, 0);
    fld_valid = 1'b0;

    // single-instruction sessions, legal and illegal
    for (int i = 0; i < 12; i++) begin
      do_start(vecs[i].base);
      check("v_err_clr", {err, err_code}, 0);
      check("v_hold", cpu_hold, 1);
      check("v_cnt0", wr_count, 0);
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].imm, 1'b1);
      if (vecs[i].legal) begin
        check("v_we", imem_we, 1);
        check("v_addr", imem_addr, vecs[i].base);
        check("v_wdata", imem_wdata, vecs[i].word);
        tick();
        check("v_we_off", imem_we, 0);
        check("v_done", done, 1);
        check("v_hold_rel", cpu_hold, 0);
        check("v_cnt1", wr_count, 1);
        tick();
        check("v_done_pulse", done, 0);
      end else begin
        check("v_nowrite", imem_we, 0);
        check("v_err", err, 1);
        check("v_code", err_code, vecs[i].code);
        check("v_hold_err", cpu_hold, 1);
        check("v_ready_err", fld_ready, 0);
        tick();
        check("v_cnt_err", wr_count, 0);
        check("v_err_sticky", err, 1);
      end
    end

    // three-word program from base 0
    do_start(8'h00);
    send(4'h9, 3'd2, 3'd0, 3'd0, 12'hFFF, 1'b0);
    check("m0_addr", imem_addr, 8'h00);
    check("m0_wdata", imem_wdata, 16'h943F);
    tick();
    check("m0_ready", fld_ready, 1);
    check("m0_cnt", wr_count, 1);
    send(4'hD, 3'd0, 3'd0, 3'd0, 12'hABC, 1'b0);
    check("m1_addr", imem_addr, 8'h01);
    check("m1_wdata", imem_wdata, 16'hDABC);
    send(4'h0, 3'd0, 3'd0, 3'd0, 12'h000, 1'b1);
    check("m2_we", imem_we, 1);
    check("m2_addr", imem_addr, 8'h02);
    check("m2_wdata", imem_wdata, 16'h0000);
    tick();
    check("m_done", done, 1);
    check("m_cnt", wr_count, 3);

    // start during LOAD is ignored
    do_start(8'h40);
    start = 1'b1; base_addr = 8'h80;
    tick();
    start = 1'b0;
    send(4'h1, 3'd1, 3'd2, 3'd3, 12'h000, 1'b1);
    check("ign_addr", imem_addr, 8'h40);
    tick();

    // address overflow at the top of memory
    do_start(8'hFF);
    send(4'h1, 3'd1, 3'd2, 3'd3, 12'h000, 1'b0);
    check("ovf_we", imem_we, 1);
    check("ovf_addr", imem_addr, 8'hFF);
    tick();
    check("ovf_err", {err, err_code}, 3'b111);
    check("ovf_cnt", wr_count, 1);
    check("ovf_hold", cpu_hold, 1);
    w0 = wr_seen;
    fld_opcode = 4'h2; fld_last = 1'b0; fld_valid = 1'b1;
    repeat (5) tick();
    check("ovf_ready", fld_ready, 0);
    check("ovf_nowrite", wr_seen, w0);
    fld_valid = 1'b0;

    // reset asserted during WRITE
    do_start(8'h33);
    send(4'h3, 3'd1, 3'd1, 3'd1, 12'h000, 1'b0);
    check("rw_we", imem_we, 1);
    rst_n = 1'b0;
    #1;
    check("rw_we_drop", imem_we, 0);
    check("rw_addr", imem_addr, 0);
    check("rw_wdata", imem_wdata, 0);
    check("rw_hold", cpu_hold, 0);
    check("rw_ready", fld_ready, 0);
    check("rw_cnt", wr_count, 0);
    check("rw_flags", {done, err, err_code}, 0);
    #2;
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
